fc_hdr_extract: RTL and testbench
=================================

FC_HDR_EXTRACT -- requirements
Module: fc_hdr_extract

Interface
REQ-001 Parameter MAX_WORDS, default 537: largest legal frame length in 32-bit words (header+payload+CRC).
REQ-002 Parameter MIN_WORDS, default 7: smallest legal frame length in words (6 header words + CRC).
REQ-003 iCLK  input  1  212.5 MHz clock; the block's only clock.
REQ-004 iRESET_n  input  1  reset, asynchronous and active-low.
REQ-005 iDATA  input  32  frame word from upstream IPG smoothing stage (registered stream).
REQ-006 iSOP / iEOP / iERR / iDVAL  input  1 each  start, end, MTIP error and data-valid, qualified by iDVAL.
REQ-007 oHDR  output  192  captured FC header words 0..5; word 0 in bits [191:160].
REQ-008 oLEN  output  10  total word count of the completed frame, SOP through EOP inclusive.
REQ-009 oFLAGS  output  4  {abort, giant, runt, mtip_err}; bit 0 is mtip_err.
REQ-010 oHDR_VAL  output  1  one-cycle pulse; oHDR, oLEN and oFLAGS are valid while it is high.
REQ-011 oORPHAN  output  1  one-cycle pulse when a valid word arrives outside any frame.
REQ-012 oFRAME_CNT / oERR_CNT  output  32 each  statistics counters (see Configuration).

Function
REQ-013 The FSM SHALL have four states: IDLE, HDR (capturing header words 0..5), BODY and FLUSH; reset state is IDLE.
REQ-014 IDLE: iDVAL&iSOP SHALL capture iDATA into header word 0, set the word count to 1, clear the flags and go to HDR; iDVAL without iSOP SHALL pulse oORPHAN the next cycle and stay in IDLE.
REQ-015 HDR: each valid word SHALL be stored at the index equal to the word count; after word 5 is stored the FSM SHALL go to BODY.
REQ-016 BODY: valid words SHALL only increment the word count; the count SHALL saturate at 1023 with no wrap.
REQ-017 On a valid iEOP in any in-frame state, the FSM SHALL go to FLUSH; FLUSH SHALL assert oHDR_VAL for exactly one cycle and then return to IDLE.
REQ-018 Latency: oHDR_VAL SHALL be high exactly 1 cycle after the iEOP word cycle.
REQ-019 Single-word frame (iSOP & iEOP on the same valid cycle): the FSM SHALL go straight to FLUSH with oLEN=1 and runt=1.
REQ-020 runt SHALL be set when the final count is less than MIN_WORDS; giant SHALL be set when the final count is greater than MAX_WORDS; both are evaluated using the EOP word.
REQ-021 mtip_err SHALL be the OR of iERR over every valid word of the frame.
REQ-022 iSOP while in HDR or BODY: the old frame SHALL be reported next cycle with abort=1 and its length counted up to the word before the new SOP; the new SOP word SHALL start the next frame without loss.
REQ-023 FLUSH is a single cycle; a valid iSOP arriving in FLUSH SHALL be accepted as in IDLE, so back-to-back frames lose no data.
REQ-024 Header words not received (short frames) SHALL read as zero in oHDR.
REQ-025 oHDR, oLEN and oFLAGS SHALL hold their values until the next oHDR_VAL.
REQ-026 iDATA SHALL be ignored whenever iDVAL=0; the FSM SHALL not advance on invalid cycles.

Reset
REQ-027 Assertion of iRESET_n low SHALL asynchronously force state IDLE and drive all outputs, counters and header registers to zero.
REQ-028 A frame in progress at reset SHALL be discarded without an oHDR_VAL pulse; after release, words before the next SOP SHALL be treated as orphans.

Configuration
REQ-029 Macro FC_HDR_STATS_EN defined: oFRAME_CNT SHALL increment on every oHDR_VAL; oERR_CNT SHALL increment on every oHDR_VAL with any flag set and on every oORPHAN; both counters saturate at 0xFFFFFFFF.
REQ-030 FC_HDR_STATS_EN undefined: oFRAME_CNT and oERR_CNT SHALL be constant zero and the counter logic SHALL be absent.

Structure
REQ-031 Shared package fc_hdr_pkg SHALL hold the FSM state typedef, the header word count (6), the flag bit indices and the oLEN width.
REQ-032 A sub-module fc_sat_cntr (32-bit saturating increment counter, async active-low reset) SHALL implement both statistics counters.

Verification
REQ-033 Frame of 10 words, header 0x22000001..0x22000006 -> oHDR_VAL 1 cycle after EOP, oLEN=10, oFLAGS=0, oHDR word0=0x22000001.
REQ-034 Single-word frame (SOP+EOP) -> oLEN=1, oFLAGS=4'b0010; 3-word frame -> oLEN=3, runt=1, oHDR words 3..5 = 0.
REQ-035 540-word frame with iERR on word 200 -> oLEN=540, oFLAGS=4'b0101.
REQ-036 SOP at word 8 of an open frame, then a 7-word frame -> first report oLEN=7 with abort=1, second report oLEN=7 with oFLAGS=0.
REQ-037 2 valid words with no SOP in IDLE -> two oORPHAN pulses; with FC_HDR_STATS_EN, oERR_CNT=2 and oFRAME_CNT=0.
REQ-038 Reset asserted at word 4 of a frame, then a clean 8-word frame -> no report for the first frame, one report for the second with oLEN=8.

Source files
------------

// File: rtl/fc_hdr_pkg.sv
// Shared types and constants for the FC header extractor.
package fc_hdr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StBody,
        StFlush
    } state_e;

    localparam int unsigned HdrWords = 6;
    localparam int unsigned LenW     = 10;
    localparam int unsigned FlagW    = 4;

    localparam int unsigned FlagMtip  = 0;
    localparam int unsigned FlagRunt  = 1;
    localparam int unsigned FlagGiant = 2;
    localparam int unsigned FlagAbort = 3;

    // Assemble the flag vector from its named fields.
    function automatic logic [FlagW-1:0] mk_flags(input logic abort, input logic giant,
                                                  input logic runt, input logic mtip);
        logic [FlagW-1:0] f;
        f            = '0;
        f[FlagAbort] = abort;
        f[FlagGiant] = giant;
        f[FlagRunt]  = runt;
        f[FlagMtip]  = mtip;
        return f;
    endfunction

endpackage

// File: rtl/fc_sat_cntr.sv
// 32-bit saturating event counter.
module fc_sat_cntr (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    // Count events, holding at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fc_hdr_extract.sv
// FC frame header extractor: captures header words 0..5, counts frame length
// and reports {abort, giant, runt, mtip_err} one cycle after the closing word.
// Define FC_HDR_STATS_EN to build the frame / error statistics counters.
module fc_hdr_extract
    import fc_hdr_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 537,
    parameter int unsigned MIN_WORDS = 7
) (
    input  logic                  iCLK,
    input  logic                  iRESET_n,
    input  logic [31:0]           iDATA,
    input  logic                  iSOP,
    input  logic                  iEOP,
    input  logic                  iERR,
    input  logic                  iDVAL,
    output logic [32*HdrWords-1:0] oHDR,
    output logic [LenW-1:0]       oLEN,
    output logic [FlagW-1:0]      oFLAGS,
    output logic                  oHDR_VAL,
    output logic                  oORPHAN,
    output logic [31:0]           oFRAME_CNT,
    output logic [31:0]           oERR_CNT
);

    state_e                     state_q;
    logic [0:HdrWords-1][31:0]  hdr_q, hdr_upd, rpt_hdr, out_hdr_q;
    logic [LenW-1:0]            cnt_q, cnt_inc, rpt_len, out_len_q;
    logic [FlagW-1:0]           rpt_flags, out_flags_q;
    logic                       err_q, err_acc, pend_q;
    logic                       rpt_fire, hdr_val_q, orphan_q;
    logic                       in_frame, sop_v, eop_v, slot_busy;

    function automatic logic [FlagW-1:0] len_flags(input logic abort, input logic [LenW-1:0] len,
                                                   input logic mtip);
        return mk_flags(abort, 32'(len) > MAX_WORDS, 32'(len) < MIN_WORDS, mtip);
    endfunction

    assign in_frame  = (state_q == StHdr) || (state_q == StBody);
    assign sop_v     = iDVAL && iSOP;
    assign eop_v     = iDVAL && iEOP;
    // A SOP+EOP word that collides with another report is deferred to FLUSH.
    assign slot_busy = in_frame || ((state_q == StFlush) && pend_q);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign err_acc   = err_q | iERR;

    // Header image with the current word written at its index while in HDR.
    always_comb begin
        hdr_upd = hdr_q;
        for (int i = 1; i < HdrWords; i++) begin
            if ((state_q == StHdr) && (cnt_q == LenW'(i))) hdr_upd[i] = iDATA;
        end
    end

    // Select which frame, if any, is reported on the next cycle.
    always_comb begin
        rpt_fire  = 1'b0;
        rpt_hdr   = hdr_q;
        rpt_len   = cnt_q;
        rpt_flags = '0;
        if ((state_q == StFlush) && pend_q) begin
            rpt_fire  = 1'b1;
            rpt_flags = len_flags(1'b0, cnt_q, err_q);
        end else if (in_frame && sop_v) begin
            rpt_fire  = 1'b1;
            rpt_flags = len_flags(1'b1, cnt_q, err_q);
        end else if (in_frame && eop_v) begin
            rpt_fire  = 1'b1;
            rpt_hdr   = hdr_upd;
            rpt_len   = cnt_inc;
            rpt_flags = len_flags(1'b0, cnt_inc, err_acc);
        end else if (sop_v && eop_v) begin
            rpt_fire  = 1'b1;
            rpt_hdr   = {iDATA, {(HdrWords-1)*32{1'b0}}};
            rpt_len   = LenW'(1);
            rpt_flags = len_flags(1'b0, LenW'(1), iERR);
        end
    end

    // Frame FSM with working capture registers and registered report outputs.
    always_ff @(posedge iCLK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            state_q     <= StIdle;
            hdr_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            out_hdr_q   <= '0;
            out_len_q   <= '0;
            out_flags_q <= '0;
            hdr_val_q   <= 1'b0;
            orphan_q    <= 1'b0;
        end else begin
            hdr_val_q <= rpt_fire;
            orphan_q  <= 1'b0;
            if (rpt_fire) begin
                out_hdr_q   <= rpt_hdr;
                out_len_q   <= rpt_len;
                out_flags_q <= rpt_flags;
            end
            if (sop_v) begin
                hdr_q   <= {iDATA, {(HdrWords-1)*32{1'b0}}};
                cnt_q   <= LenW'(1);
                err_q   <= iERR;
                pend_q  <= eop_v && slot_busy;
                state_q <= eop_v ? StFlush : StHdr;
            end else if (in_frame && iDVAL) begin
                hdr_q  <= hdr_upd;
                cnt_q  <= cnt_inc;
                err_q  <= err_acc;
                pend_q <= 1'b0;
                if (iEOP) begin
                    state_q <= StFlush;
                end else if ((state_q == StHdr) && (cnt_q == LenW'(HdrWords-1))) begin
                    state_q <= StBody;
                end
            end else if (!in_frame) begin
                orphan_q <= iDVAL;
                pend_q   <= 1'b0;
                state_q  <= StIdle;
            end
        end
    end

    assign oHDR     = out_hdr_q;
    assign oLEN     = out_len_q;
    assign oFLAGS   = out_flags_q;
    assign oHDR_VAL = hdr_val_q;
    assign oORPHAN  = orphan_q;

`ifdef FC_HDR_STATS_EN
    logic err_inc;
    assign err_inc = (hdr_val_q && (|out_flags_q)) || orphan_q;

    fc_sat_cntr u_frame_cnt (
        .clk_i  (iCLK),
        .rst_ni (iRESET_n),
        .inc_i  (hdr_val_q),
        .cnt_o  (oFRAME_CNT)
    );

    fc_sat_cntr u_err_cnt (
        .clk_i  (iCLK),
        .rst_ni (iRESET_n),
        .inc_i  (err_inc),
        .cnt_o  (oERR_CNT)
    );
`else
    assign oFRAME_CNT = '0;
    assign oERR_CNT   = '0;
`endif

endmodule

// File: tb/tb_fc_hdr_extract.sv
// Scoreboard bench for fc_hdr_extract; honours FC_HDR_STATS_EN for the counters.
module tb_fc_hdr_extract;

    logic         iCLK = 1'b0;
    logic         iRESET_n;
    logic [31:0]  iDATA;
    logic         iSOP, iEOP, iERR, iDVAL;
    logic [191:0] oHDR;
    logic [9:0]   oLEN;
    logic [3:0]   oFLAGS;
    logic         oHDR_VAL, oORPHAN;
    logic [31:0]  oFRAME_CNT, oERR_CNT;

    fc_hdr_extract dut (
        .iCLK       (iCLK),
        .iRESET_n   (iRESET_n),
        .iDATA      (iDATA),
        .iSOP       (iSOP),
        .iEOP       (iEOP),
        .iERR       (iERR),
        .iDVAL      (iDVAL),
        .oHDR       (oHDR),
        .oLEN       (oLEN),
        .oFLAGS     (oFLAGS),
        .oHDR_VAL   (oHDR_VAL),
        .oORPHAN    (oORPHAN),
        .oFRAME_CNT (oFRAME_CNT),
        .oERR_CNT   (oERR_CNT)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [191:0] hdr;
        logic [9:0]   len;
        logic [3:0]   flags;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t ab_exp;
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   orph_seen = 0;
    int   n_rpt = 0;
    int   n_flag = 0;
    bit   abort_pend = 1'b0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Monitor: pop and compare on every report, flag late or surplus reports.
    always @(negedge iCLK) begin
        if (iRESET_n) begin
            if (oORPHAN) orph_seen++;
            if (oHDR_VAL) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_report: got len %0d, expected no report", oLEN);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rpt_cycle", 192'(cyc), 192'(mon_e.cyc));
                    chk("rpt_len", 192'(oLEN), 192'(mon_e.len));
                    chk("rpt_flags", 192'(oFLAGS), 192'(mon_e.flags));
                    chk("rpt_hdr", oHDR, mon_e.hdr);
                end
            end else if ((sb.size() > 0) && (cyc > sb[0].cyc)) begin
                mon_e = sb.pop_front();
                checks++;
                $display("FAIL report_missing: got none, expected len %0d at cycle %0d",
                         mon_e.len, mon_e.cyc);
            end
        end
    end

    task automatic word(input logic [31:0] d, input logic s, input logic e, input logic r);
        iDATA = d; iSOP = s; iEOP = e; iERR = r; iDVAL = 1'b1;
        @(posedge iCLK); #1;
    endtask

    task automatic idle(input int n);
        iDATA = '0; iSOP = 1'b0; iEOP = 1'b0; iERR = 1'b0; iDVAL = 1'b0;
        repeat (n) begin @(posedge iCLK); #1; end
    endtask

    function automatic logic [191:0] mk_hdr(input int n, input logic [31:0] base);
        logic [191:0] h;
        h = '0;
        for (int i = 0; i < 6; i++) if (i < n) h[191-32*i -: 32] = base + 32'(i + 1);
        return h;
    endfunction

    task automatic push(input exp_t x);
        sb.push_back(x);
        n_rpt++;
        if (x.flags != 4'b0) n_flag++;
    endtask

    // Complete frame: word i carries base+i+1, iERR on word err_at (-1 = none).
    task automatic frame(input int n, input logic [31:0] base, input int err_at);
        exp_t x;
        x.hdr   = mk_hdr(n, base);
        x.len   = (n > 1023) ? 10'd1023 : 10'(n);
        x.flags = {1'b0, n > 537, n < 7, (err_at >= 0) && (err_at < n)};
        for (int i = 0; i < n; i++) begin
            word(base + 32'(i + 1), i == 0, i == n - 1, i == err_at);
            if ((i == 0) && abort_pend) begin
                ab_exp.cyc = cyc;
                push(ab_exp);
                abort_pend = 1'b0;
            end
        end
        x.cyc = cyc;
        push(x);
    endtask

    // Frame left open; the next SOP is expected to report it as aborted.
    task automatic open_frame(input int n, input logic [31:0] base);
        ab_exp.hdr   = mk_hdr(n, base);
        ab_exp.len   = 10'(n);
        ab_exp.flags = {1'b1, n > 537, n < 7, 1'b0};
        for (int i = 0; i < n; i++) word(base + 32'(i + 1), i == 0, 1'b0, 1'b0);
        abort_pend = 1'b1;
    endtask

    initial begin
        iRESET_n = 1'b0;
        iDATA = '0; iSOP = 1'b0; iEOP = 1'b0; iERR = 1'b0; iDVAL = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_hdr_val", 192'(oHDR_VAL), 192'(0));
        chk("rst_len", 192'(oLEN), 192'(0));
        chk("rst_hdr", oHDR, 192'(0));
        iRESET_n = 1'b1;
        idle(2);

        frame(10, 32'h2200_0000, -1);
        idle(4);
        chk("len_hold", 192'(oLEN), 192'(10));
        frame(1, 32'h3300_0000, -1);
        frame(3, 32'h3400_0000, -1);
        idle(2);
        frame(540, 32'h3500_0000, 200);
        idle(2);
        open_frame(7, 32'h3600_0000);
        frame(7, 32'h3700_0000, -1);
        idle(3);

        // Reset part-way through a frame: nothing may be reported for it.
        open_frame(4, 32'h3800_0000);
        iRESET_n = 1'b0;
        abort_pend = 1'b0;
        #2;
        chk("mid_rst_len", 192'(oLEN), 192'(0));
        chk("mid_rst_flags", 192'(oFLAGS), 192'(0));
        chk("mid_rst_hdr", oHDR, 192'(0));
        chk("mid_rst_fcnt", 192'(oFRAME_CNT), 192'(0));
        chk("mid_rst_ecnt", 192'(oERR_CNT), 192'(0));
        n_rpt = 0; n_flag = 0; orph_seen = 0;
        idle(2);
        iRESET_n = 1'b1;
        idle(1);

        word(32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
        word(32'hDEAD_0002, 1'b0, 1'b0, 1'b0);
        frame(8, 32'h3900_0000, -1);
        idle(6);

        chk("sb_drained", 192'(sb.size()), 192'(0));
        chk("orphans", 192'(orph_seen), 192'(2));
`ifdef FC_HDR_STATS_EN
        chk("frame_cnt", 192'(oFRAME_CNT), 192'(n_rpt));
        chk("err_cnt", 192'(oERR_CNT), 192'(n_flag + 2));
`else
        chk("frame_cnt_off", 192'(oFRAME_CNT), 192'(0));
        chk("err_cnt_off", 192'(oERR_CNT), 192'(0));
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
